uart_tx_mmio: RTL and testbench



---
 rtl/uart_tx_mmio.sv | 208 ++++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: byte FIFO feeding a baud-timed serialiser (8N1).
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1).
module uart_tx_mmio #(
  parameter int BAUD_DIV   = 200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         io_wen,
  input  logic [7:0]                   io_wdata,
  input  logic                         clr_ovf,
  output logic                         fifo_full,
  output logic                         fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         tx_busy,
  output logic                         ovf,
  output logic                         tx,
  output logic [2:0]                   dbg_state
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    , S_PARITY = 3'd4
`endif
  } state_e;

  // io_wen is a one-cycle strobe with no back-pressure: it is accepted when the
  // FIFO is not full and otherwise dropped, which sets the sticky ovf flag.
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  state_e        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic          parity_q, parity_d;
`endif

  logic       wr_acc, wr_drop, pop, baud_done;
  logic [7:0] head;

  assign fifo_count = count_q;
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign ovf        = ovf_q;
  assign tx         = tx_q;
  assign tx_busy    = (state_q != S_IDLE);
  assign dbg_state  = state_q;

  assign wr_acc    = io_wen & ~fifo_full;
  assign wr_drop   = io_wen & fifo_full;
  assign head      = mem_q[rd_ptr_q];
  assign baud_done = (baud_q == '0);

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= io_wdata;
  end

  always_comb begin
    wr_ptr_d = wr_acc ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop    ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({wr_acc, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A dropped write beats a simultaneous clear.
    ovf_d = wr_drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop      = 1'b1;
          shift_d  = head;
          baud_d   = BAUD_MAX;
          tx_d     = 1'b0;
          state_d  = S_START;
`ifdef UART_TX_PARITY_EN
          parity_d = ^head;
`endif
        end
      end
      S_START: begin
        if (baud_done) begin
          baud_d  = BAUD_MAX;
          tx_d    = shift_q[0];
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_d = BAUD_MAX;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = S_PARITY;
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_done) begin
          baud_d  = BAUD_MAX;
          tx_d    = 1'b1;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
`endif
      S_STOP: begin
        if (baud_done) begin
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            pop      = 1'b1;
            shift_d  = head;
            baud_d   = BAUD_MAX;
            tx_d     = 1'b0;
            state_d  = S_START;
`ifdef UART_TX_PARITY_EN
            parity_d = ^head;
`endif
          end else begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio at BAUD_DIV=4, FIFO_DEPTH=8; parity steps
// are included when UART_TX_PARITY_EN is defined.
module tb_uart_tx_mmio;
  localparam int BAUD  = 4;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       io_wen = 1'b0;
  logic [7:0] io_wdata = 8'h00;
  logic       clr_ovf = 1'b0;
  logic       fifo_full, fifo_empty, tx_busy, ovf, tx;
  logic [3:0] fifo_count;
  logic [2:0] dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pop_cyc;
  logic [10:0] frame;

  uart_tx_mmio #(.BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .io_wen     (io_wen),
    .io_wdata   (io_wdata),
    .clr_ovf    (clr_ovf),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .fifo_count (fifo_count),
    .tx_busy    (tx_busy),
    .ovf        (ovf),
    .tx         (tx),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  // Called just after a pop edge; checks tx for every cycle of the frame and
  // returns just after the edge that ends the stop bit.
  task automatic expect_frame(input string tag, input logic [10:0] f, input int nbits);
    for (int k = 0; k < nbits; k++) begin
      for (int c = 0; c < BAUD; c++) begin
        check($sformatf("%s_tx_b%0d_c%0d", tag, k, c), tx, f[k]);
        if (c == 0) check($sformatf("%s_busy_b%0d", tag, k), tx_busy, 1'b1);
        tick();
      end
    end
  endtask

  initial begin
    // reset values
    #12;
    check("rst_tx", tx, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_empty", fifo_empty, 1'b1);
    check("rst_full", fifo_full, 1'b0);
    check("rst_count", fifo_count, 4'd0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_state", dbg_state, 3'd0);
    rst = 1'b1;
    tick();
    tick();

    // step 1: single 0xA5 frame
    io_wen = 1'b1; io_wdata = 8'hA5;
    tick();
    io_wen = 1'b0;
    check("s1_count_after_wr", fifo_count, 4'd1);
    check("s1_tx_before_pop", tx, 1'b1);
    check("s1_busy_before_pop", tx_busy, 1'b0);
    tick();
    check("s1_empty_after_pop", fifo_empty, 1'b1);
    expect_frame("s1", {1'b0, 1'b1, 8'hA5, 1'b0}, 10);
    check("s1_busy_end", tx_busy, 1'b0);
    check("s1_tx_end", tx, 1'b1);
    tick();

    // step 2: back-to-back 0x00, 0xFF
    io_wen = 1'b1; io_wdata = 8'h00;
    tick();
    check("s2_count_a", fifo_count, 4'd1);
    io_wdata = 8'hFF;
    tick();
    io_wen = 1'b0;
    check("s2_count_b", fifo_count, 4'd1);
    expect_frame("s2a", {1'b0, 1'b1, 8'h00, 1'b0}, 10);
    check("s2_count_c", fifo_count, 4'd0);
    check("s2_busy_gap", tx_busy, 1'b1);
    expect_frame("s2b", {1'b0, 1'b1, 8'hFF, 1'b0}, 10);
    check("s2_busy_end", tx_busy, 1'b0);
    check("s2_empty_end", fifo_empty, 1'b1);
    tick();

    // step 3: overflow with 10 consecutive writes
    for (int i = 0; i < 10; i++) begin
      io_wen = 1'b1; io_wdata = 8'h10 + 8'(i);
      tick();
      if (i == 1) begin
        pop_cyc = cyc;
        check("s3_tx_start", tx, 1'b0);
      end
    end
    io_wen = 1'b0;
    check("s3_count_full", fifo_count, 4'd8);
    check("s3_full", fifo_full, 1'b1);
    check("s3_ovf_set", ovf, 1'b1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("s3_ovf_clr", ovf, 1'b0);
    io_wen = 1'b1; io_wdata = 8'hEE; clr_ovf = 1'b1;
    tick();
    io_wen = 1'b0; clr_ovf = 1'b0;
    check("s3_ovf_set_wins", ovf, 1'b1);
    check("s3_count_still_full", fifo_count, 4'd8);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("s3_ovf_clr2", ovf, 1'b0);
    for (int j = 0; j < 9; j++) begin
      frame = {1'b0, 1'b1, 8'h10 + 8'(j), 1'b0};
      for (int k = 0; k < 10; k++) begin
        run_to(pop_cyc + 40 * j + 4 * k + 2);
        check($sformatf("s3_byte%0d_bit%0d", j, k), tx, frame[k]);
        if (k == 0) check($sformatf("s3_count_byte%0d", j), fifo_count, 32'(8 - j));
      end
    end
    run_to(pop_cyc + 360);
    check("s3_busy_end", tx_busy, 1'b0);
    check("s3_empty_end", fifo_empty, 1'b1);
    tick();

    // step 4: asynchronous reset during data bit 3 of 0x55
    io_wen = 1'b1; io_wdata = 8'h55;
    tick();
    io_wdata = 8'hAA;
    tick();
    io_wen = 1'b0;
    repeat (17) tick();
    check("s4_tx_bit3", tx, 1'b0);
    check("s4_count_queued", fifo_count, 4'd1);
    #2;
    rst = 1'b0;
    #1;
    check("s4_rst_tx", tx, 1'b1);
    check("s4_rst_busy", tx_busy, 1'b0);
    check("s4_rst_empty", fifo_empty, 1'b1);
    check("s4_rst_count", fifo_count, 4'd0);
    check("s4_rst_state", dbg_state, 3'd0);
    tick();
    check("s4_rst_hold_tx", tx, 1'b1);
    #3;
    rst = 1'b1;
    tick();
    check("s4_post_tx", tx, 1'b1);
    check("s4_post_busy", tx_busy, 1'b0);
    io_wen = 1'b1; io_wdata = 8'h3C;
    tick();
    io_wen = 1'b0;
    check("s4_count_wr", fifo_count, 4'd1);
    tick();
    expect_frame("s4", {1'b0, 1'b1, 8'h3C, 1'b0}, 10);
    check("s4_busy_end", tx_busy, 1'b0);
    tick();

`ifdef UART_TX_PARITY_EN
    // step 5: even parity bit
    io_wen = 1'b1; io_wdata = 8'h07;
    tick();
    io_wen = 1'b0;
    tick();
    expect_frame("s5a", {1'b1, 1'b1, 8'h07, 1'b0}, 11);
    check("s5a_busy_end", tx_busy, 1'b0);
    tick();
    io_wen = 1'b1; io_wdata = 8'h03;
    tick();
    io_wen = 1'b0;
    tick();
    expect_frame("s5b", {1'b1, 1'b0, 8'h03, 1'b0}, 11);
    check("s5b_busy_end", tx_busy, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
